// File: rtl/fft_pkg.sv
// Shared constants, FSM state encodings and the bit-reversal helper for the
// radix-2 FFT sequencer.
package fft_pkg;

    localparam int LOG2N = 10;
    localparam int N     = 2 ** LOG2N;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t LOAD   = 3'd1;
    localparam state_t RUN    = 3'd2;
    localparam state_t DRAIN  = 3'd3;
    localparam state_t UNLOAD = 3'd4;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] v, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) begin
                r[i] = v[w-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_unload_ctrl.sv
// Result streaming for the FFT sequencer: issues RAM reads and presents the
// registered results on a valid/ready interface with zero-bubble throughput.
module fft_unload_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N      = fft_pkg::LOG2N,
    parameter bit BITREV_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             out_ready_i,
    output logic             re_o,
    output logic [LOG2N-1:0] addr_o,
    output logic             valid_o,
    output logic             last_o,
    output logic             finished_o
);

    localparam int N = 2 ** LOG2N;
    localparam logic [LOG2N:0]   CNT_END  = (LOG2N+1)'(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    logic [LOG2N:0]   cnt_q, cnt_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [LOG2N-1:0] natAddr;
    logic [15:0]      revAddr;

    // idx_q remembers which item the RAM output currently holds so that
    // last can be qualified on the presented item, not the issued one.
    always_comb begin
        natAddr = cnt_q[LOG2N-1:0];
        revAddr = bitrev(16'(natAddr), LOG2N);
        re_o    = enable_i && (cnt_q < CNT_END) && (!valid_q || out_ready_i);
        addr_o  = '0;
        if (enable_i) begin
            addr_o = BITREV_OUT ? revAddr[LOG2N-1:0] : natAddr;
        end

        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (!enable_i) begin
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (re_o) begin
            cnt_d   = cnt_q + 1'b1;
            idx_d   = natAddr;
            valid_d = 1'b1;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end

        valid_o    = valid_q;
        last_o     = valid_q && (idx_q == LAST_IDX);
        finished_o = last_o && out_ready_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fft_ctrl.sv
// Top-level sequencer for the in-place radix-2 FFT: load, LOG2N butterfly
// stages separated by pipeline drains, then streamed unload.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N      = fft_pkg::LOG2N,
    parameter int BFLY_LAT   = 4,
    parameter bit BITREV_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic             load_we_o,
    output logic [LOG2N-1:0] load_addr_o,
    output logic             agu_start_o,
    output logic             bfly_en_o,
    output logic [3:0]       stage_o,
    output logic [LOG2N-2:0] bfly_idx_o,
    output logic             memsel_o,
    output logic             unload_re_o,
    output logic [LOG2N-1:0] unload_addr_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i
);

    localparam int N  = 2 ** LOG2N;
    localparam int BW = LOG2N - 1;
    localparam int DW = $clog2(BFLY_LAT + 1);

    localparam logic [LOG2N-1:0] LOAD_LAST   = LOG2N'(N - 1);
    localparam logic [BW-1:0]    BFLY_LAST   = BW'(N / 2 - 1);
    localparam logic [3:0]       STAGE_LAST  = 4'(LOG2N - 1);
    localparam logic [DW-1:0]    DRN_INIT    = DW'(BFLY_LAT);
    localparam logic             RESULT_BANK = 1'(LOG2N % 2);

    state_t          state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [3:0]       stage_q, stage_d;
    logic [BW-1:0]    bfly_q, bfly_d;
    logic [DW-1:0]    drn_q, drn_d;
    logic             done_q, done_d;
    logic             unlFinished;

    fft_unload_ctrl #(
        .LOG2N      (LOG2N),
        .BITREV_OUT (BITREV_OUT)
    ) u_unload (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (state_q == UNLOAD),
        .out_ready_i (out_ready_i),
        .re_o        (unload_re_o),
        .addr_o      (unload_addr_o),
        .valid_o     (out_valid_o),
        .last_o      (out_last_o),
        .finished_o  (unlFinished)
    );

    assign in_ready_o = (state_q == LOAD);
    assign load_we_o  = in_valid_i && in_ready_o;

    // Next-state logic; every counter stops on a terminal compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        drn_d   = drn_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (load_we_o) begin
                    if (cnt_q == LOAD_LAST) begin
                        state_d = RUN;
                        stage_d = '0;
                        bfly_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (bfly_q == BFLY_LAST) begin
                    state_d = DRAIN;
                    drn_d   = DRN_INIT;
                end else begin
                    bfly_d = bfly_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drn_q == DW'(1)) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = UNLOAD;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + 1'b1;
                        bfly_d  = '0;
                    end
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end
            UNLOAD: begin
                if (unlFinished) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath-facing outputs are gated by state so idle and reset show zeros.
    always_comb begin
        busy_o      = (state_q != IDLE);
        done_o      = done_q;
        load_addr_o = (state_q == LOAD) ? cnt_q : '0;
        bfly_en_o   = (state_q == RUN);
        agu_start_o = (state_q == RUN) && (stage_q == 4'd0) && (bfly_q == '0);
        bfly_idx_o  = (state_q == RUN) ? bfly_q : '0;
        stage_o     = '0;
        memsel_o    = 1'b0;
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            stage_o  = stage_q;
            memsel_o = stage_q[0];
        end else if (state_q == UNLOAD) begin
            memsel_o = RESULT_BANK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
            drn_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            drn_q   <= drn_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: doc/fft_ctrl.md
Name: fft_ctrl

Overview:
Top-level sequencer for the in-place radix-2 FFT core. Loads N samples into bank 0 and steps the butterfly datapath and address generator through LOG2N stages. Inserts pipeline-drain bubbles between stages and ping-pongs the memory bank select. Then streams the N results out through a valid/ready interface.

Parameters:
LOG2N, 10, log2 of transform size; N = 2**LOG2N, N/2 butterflies per stage
BFLY_LAT, 4, butterfly read-to-writeback latency in cycles; sets drain length
BITREV_OUT, 1, 1: unload addresses bit-reversed; 0: natural order

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start request; honoured only in IDLE
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after the last result is accepted
in_valid_i  in  1  input sample valid
in_ready_o  out  1  high throughout LOAD
load_we_o  out  1  sample RAM write enable, = in_valid_i & in_ready_o
load_addr_o  out  LOG2N  write address, natural order
agu_start_o  out  1  one-cycle pulse on the first cycle of stage 0
bfly_en_o  out  1  butterfly issue enable
stage_o  out  4  current stage 0..LOG2N-1
bfly_idx_o  out  LOG2N-1  butterfly index within the stage
memsel_o  out  1  bank select
unload_re_o  out  1  result RAM read enable
unload_addr_o  out  LOG2N  result read address
out_valid_o  out  1  result data valid (registered)
out_last_o  out  1  qualifies the final result, index N-1
out_ready_i  in  1  downstream accept

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all counters 0; every output 0. Reset mid-operation aborts immediately and does not pulse done_o.
- States: IDLE, LOAD, RUN, DRAIN, UNLOAD.
- IDLE: if start_i, go to LOAD with cnt=0. Otherwise stay.
- LOAD:
  - in_ready_o=1, memsel_o=0, load_addr_o=cnt.
  - Each accepted sample increments cnt.
  - When sample N-1 is accepted, go to RUN with stage=0 and bfly_idx=0.
  - Gaps in in_valid_i only stall. Samples are never dropped or duplicated.
- RUN:
  - bfly_en_o=1 every cycle. bfly_idx_o counts 0..N/2-1.
  - memsel_o = stage[0]: read bank stage[0], write bank ~stage[0].
  - agu_start_o=1 only on the first RUN cycle of stage 0.
  - After bfly_idx = N/2-1, go to DRAIN with drain counter = BFLY_LAT.
- DRAIN:
  - bfly_en_o=0. stage_o and memsel_o hold.
  - Lasts exactly BFLY_LAT cycles.
  - Exit: if stage = LOG2N-1, go to UNLOAD with cnt=0; else stage+1 and back to RUN.
  - Total compute time = LOG2N*(N/2+BFLY_LAT) cycles, i.e. 5160 at the defaults.
- UNLOAD:
  - memsel_o = LOG2N[0], the bank holding the results.
  - Read issue: unload_re_o = (cnt<N) & (!out_valid_o | out_ready_i).
  - unload_addr_o = BITREV_OUT ? bitrev(cnt) : cnt. cnt increments on each read.
  - out_valid_o next = unload_re_o ? 1 : (out_ready_i ? 0 : out_valid_o).
  - out_last_o = out_valid_o & (index of the presented item = N-1).
  - RAM contract: 1-cycle read latency, and the output holds while unload_re_o=0. This gives zero-bubble streaming when out_ready_i is held 1.
  - When the last item is accepted (out_valid_o & out_ready_i & out_last_o): go to IDLE and pulse done_o for one cycle.
- start_i outside IDLE is ignored. Simultaneous start_i and reset: reset wins.
- All counters wrap-free: terminal compares only, no modulo arithmetic.

Decomposition:
- Package fft_pkg holds:
  - LOG2N and N constants;
  - the state enum (IDLE, LOAD, RUN, DRAIN, UNLOAD);
  - the bitrev function, parameterised by LOG2N.
- One sub-module, fft_unload_ctrl, owns the read-issue, out_valid, out_last and cnt logic of UNLOAD.
  - Inputs: enable, out_ready_i.
  - Outputs: re, addr, valid, last, finished.
- fft_ctrl keeps the FSM plus the load, stage and drain counters.

Test Plan:
- Nominal run (defaults): start_i pulse, 1024 back-to-back samples, out_ready_i=1 → load_addr_o 0..1023. First RUN cycle at load-end+1 with agu_start_o=1. 5160 compute cycles with bfly_en_o low for exactly 4 cycles after each stage. memsel_o follows 0,1,0…1. Then 1024 results, last at unload_addr_o=bitrev(1023)=1023, out_last_o coincident, done_o on the following cycle.
- LOG2N=4, BITREV_OUT=1: unload_addr_o sequence 0,8,4,12,2,…,15. stage_o steps 0..3, 8 butterflies each.
- Input backpressure: in_valid_i toggling 1,0,1,0 → load completes after 2N-1 cycles with no address skipped or repeated.
- Output backpressure: out_ready_i low for 5 cycles mid-UNLOAD → out_valid_o stays 1, unload_re_o stays 0, presented item unchanged, no loss or duplication.
- Reset in RUN at stage 3 → next cycle all outputs 0, state IDLE, no done_o. A new start_i restarts LOAD at address 0.
- start_i asserted during RUN and UNLOAD → ignored; exactly one done_o per accepted start.
